// File: rtl/alu_pkg.sv
// Shared opcode, flag and state definitions for the pipelined ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ILL0 = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_INC  = 4'h3,
    OP_DEC  = 4'h4,
    OP_OR   = 4'h5,
    OP_AND  = 4'h6,
    OP_XOR  = 4'h7,
    OP_SHR  = 4'h8,
    OP_SHL  = 4'h9,
    OP_NOT  = 4'hA,
    OP_NEG  = 4'hB,
    OP_MUL  = 4'hC,
    OP_ROR  = 4'hD,
    OP_ROL  = 4'hE,
    OP_ILLF = 4'hF
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic neg;
    logic ovf;
    logic illegal;
  } alu_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } pipe_state_e;

  function automatic logic is_illegal_op(alu_op_e op);
    return (op == OP_ILL0) || (op == OP_ILLF);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial-product step per cycle,
// WIDTH steps after start, then a one-cycle done pulse with the product held.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   iter;
  logic               running;
  logic               done_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand      <= '0;
      acc        <= '0;
      mplier     <= '0;
      iter       <= '0;
      running    <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (start) begin
        mcand   <= {{WIDTH{1'b0}}, a};
        mplier  <= b;
        acc     <= '0;
        iter    <= CNT_W'(WIDTH - 1);
        running <= 1'b1;
      end else if (running) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        if (iter == '0) begin
          running    <= 1'b0;
          done_pulse <= 1'b1;
        end else begin
          iter <= iter - 1'b1;
        end
      end
    end
  end

  assign done = done_pulse;
  assign prod = acc;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake; single-cycle ops load the result
// registers on accept, MUL is handed to the iterative multiplier.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_hi,
  output logic             alu_zero,
  output logic             alu_carry,
  output logic             alu_neg,
  output logic             alu_ovf,
  output logic             alu_illegal,
  output logic             busy
);

  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SMAX = ~SMIN;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  pipe_state_e state, state_next;
  alu_op_e     op;
  logic        init_done;
  logic        accept, load_single, start_mul, load_mul;
  logic        mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH-1:0]   res_reg, hi_reg;
  alu_flags_t         flags_reg;
  logic               valid_reg;

  logic [SHAMT_W-1:0] amt;
  logic [WIDTH:0]     add_ext, sub_ext, inc_ext, shl_ext, shr_ext;
  logic [2*WIDTH-1:0] rot_ext;
  logic [WIDTH-1:0]   ror_res, rol_res;

  logic [WIDTH-1:0]   res_next;
  logic               carry_next, ovf_next, illegal_next;
  alu_flags_t         flags_next;

  assign op  = alu_op_e'(opcode);
  assign amt = in_b[SHAMT_W-1:0];

  // init_done keeps in_ready low until the first edge after reset release
  assign in_ready    = init_done && (state == ST_IDLE) && (!valid_reg || out_ready);
  assign accept      = in_valid && in_ready;
  assign start_mul   = accept && (op == OP_MUL);
  assign load_single = accept && (op != OP_MUL);
  assign load_mul    = (state == ST_MUL) && mul_done;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_mul),
    .a     (in_a),
    .b     (in_b),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  assign add_ext = {1'b0, in_a} + {1'b0, in_b};
  assign sub_ext = {1'b0, in_a} - {1'b0, in_b};
  assign inc_ext = {1'b0, in_a} + (WIDTH+1)'(1);
  // Bit WIDTH of shl_ext and bit 0 of shr_ext catch the last bit shifted out
  assign shl_ext = {1'b0, in_a} << amt;
  assign shr_ext = {in_a, 1'b0} >> amt;
  assign rot_ext = {in_a, in_a};
  assign ror_res = WIDTH'(rot_ext >> amt);
  assign rol_res = WIDTH'(rot_ext >> (WIDTH - int'(amt)));

  always_comb begin
    res_next     = '0;
    carry_next   = 1'b0;
    ovf_next     = 1'b0;
    illegal_next = 1'b0;
    case (op)
      OP_ADD: begin
        res_next   = add_ext[WIDTH-1:0];
        carry_next = add_ext[WIDTH];
        ovf_next   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (res_next[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        res_next   = sub_ext[WIDTH-1:0];
        carry_next = sub_ext[WIDTH];
        ovf_next   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (res_next[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_INC: begin
        res_next   = inc_ext[WIDTH-1:0];
        carry_next = inc_ext[WIDTH];
        ovf_next   = (in_a == SMAX);
      end
      OP_DEC: begin
        res_next   = in_a - ONE;
        carry_next = (in_a == '0);
        ovf_next   = (in_a == SMIN);
      end
      OP_OR:  res_next = in_a | in_b;
      OP_AND: res_next = in_a & in_b;
      OP_XOR: res_next = in_a ^ in_b;
      OP_SHR: begin
        res_next   = shr_ext[WIDTH:1];
        carry_next = shr_ext[0];
      end
      OP_SHL: begin
        res_next   = shl_ext[WIDTH-1:0];
        carry_next = shl_ext[WIDTH];
      end
      OP_NOT: res_next = ~in_a;
      OP_NEG: begin
        res_next   = '0 - in_a;
        carry_next = (in_a != '0);
        ovf_next   = (in_a == SMIN);
      end
      OP_ROR: res_next = ror_res;
      OP_ROL: res_next = rol_res;
      default: illegal_next = is_illegal_op(op);
    endcase
  end

  always_comb begin
    flags_next         = '0;
    flags_next.zero    = !illegal_next && (res_next == '0);
    flags_next.carry   = carry_next;
    flags_next.neg     = res_next[WIDTH-1];
    flags_next.ovf     = ovf_next;
    flags_next.illegal = illegal_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start_mul) state_next = ST_MUL;
      ST_MUL:  if (mul_done) state_next = ST_DONE;
      ST_DONE: if (!valid_reg || out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      init_done <= 1'b0;
    end else begin
      state     <= state_next;
      init_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_reg   <= '0;
      hi_reg    <= '0;
      flags_reg <= '0;
      valid_reg <= 1'b0;
    end else if (load_single) begin
      res_reg   <= res_next;
      hi_reg    <= '0;
      flags_reg <= flags_next;
      valid_reg <= 1'b1;
    end else if (load_mul) begin
      res_reg         <= mul_prod[WIDTH-1:0];
      hi_reg          <= mul_prod[2*WIDTH-1:WIDTH];
      flags_reg.zero  <= (mul_prod == '0);
      flags_reg.carry <= |mul_prod[2*WIDTH-1:WIDTH];
      flags_reg.neg   <= mul_prod[WIDTH-1];
      flags_reg.ovf   <= 1'b0;
      flags_reg.illegal <= 1'b0;
      valid_reg       <= 1'b1;
    end else if (valid_reg && out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid   = valid_reg;
  assign alu_out     = res_reg;
  assign alu_hi      = hi_reg;
  assign alu_zero    = flags_reg.zero;
  assign alu_carry   = flags_reg.carry;
  assign alu_neg     = flags_reg.neg;
  assign alu_ovf     = flags_reg.ovf;
  assign alu_illegal = flags_reg.illegal;
  assign busy        = (state == ST_MUL);

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe at WIDTH=8.
module tb_alu_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [3:0] opcode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] alu_out;
  logic [7:0] alu_hi;
  logic       alu_zero, alu_carry, alu_neg, alu_ovf, alu_illegal;
  logic       busy;

  int checks;
  int failures;

  // {valid, hi, out, zero, carry, neg, ovf, illegal}
  wire [21:0] obs = {out_valid, alu_hi, alu_out, alu_zero, alu_carry, alu_neg, alu_ovf, alu_illegal};

  alu_pipe #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .opcode      (opcode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_out     (alu_out),
    .alu_hi      (alu_hi),
    .alu_zero    (alu_zero),
    .alu_carry   (alu_carry),
    .alu_neg     (alu_neg),
    .alu_ovf     (alu_ovf),
    .alu_illegal (alu_illegal),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one beat, waits (bounded) for acceptance, returns 1 ns after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    opcode   = op;
    in_a     = a;
    in_b     = b;
    for (int i = 0; i < 50 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL issue_timeout op=%h in_ready=%b required=1", op, in_ready);
      failures++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = 4'h0; in_a = 8'h00; in_b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({obs, in_ready, busy} !== 24'h0) begin
      $display("FAIL reset_outputs got=%h required=%h", {obs, in_ready, busy}, 24'h0);
      failures++;
    end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b0) begin
      $display("FAIL reset_ready_early got=%b required=0", in_ready);
      failures++;
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_ready_after got=%b required=1", in_ready);
      failures++;
    end
    $display("reset: in_ready=%b out_valid=%b", in_ready, out_valid);
  endtask

  task automatic test_add_sub();
    issue(4'h1, 8'hFF, 8'h01);
    checks++;
    if (obs !== {1'b1, 8'h00, 8'h00, 5'b11000}) begin
      $display("FAIL add_ff_01 got=%h required=%h", obs, {1'b1, 8'h00, 8'h00, 5'b11000});
      failures++;
    end
    $display("ADD ff+01 -> out=%h flags=%b", alu_out, obs[4:0]);
    issue(4'h2, 8'h80, 8'h01);
    checks++;
    if (obs !== {1'b1, 8'h00, 8'h7F, 5'b00010}) begin
      $display("FAIL sub_80_01 got=%h required=%h", obs, {1'b1, 8'h00, 8'h7F, 5'b00010});
      failures++;
    end
    $display("SUB 80-01 -> out=%h flags=%b", alu_out, obs[4:0]);
    issue(4'h2, 8'h01, 8'h02);
    checks++;
    if (obs !== {1'b1, 8'h00, 8'hFF, 5'b01100}) begin
      $display("FAIL sub_01_02 got=%h required=%h", obs, {1'b1, 8'h00, 8'hFF, 5'b01100});
      failures++;
    end
    $display("SUB 01-02 -> out=%h flags=%b", alu_out, obs[4:0]);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL consume_drop got=%b required=0", out_valid);
      failures++;
    end
  endtask

  task automatic test_mul();
    logic ok;
    in_valid = 1'b1; opcode = 4'hC; in_a = 8'h10; in_b = 8'h10;
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL mul_ready_pre got=%b required=1", in_ready);
      failures++;
    end
    @(posedge clk); #1;
    // upstream presents an ADD while the multiply runs; it must wait
    opcode = 4'h1; in_a = 8'h01; in_b = 8'h01;
    ok = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (!ok) begin
      $display("FAIL mul_busy_window ok=%b required=1", ok);
      failures++;
    end
    checks++;
    if ({obs, busy, in_ready} !== {1'b1, 8'h01, 8'h00, 5'b01000, 2'b00}) begin
      $display("FAIL mul_result got=%h required=%h", {obs, busy, in_ready}, {1'b1, 8'h01, 8'h00, 5'b01000, 2'b00});
      failures++;
    end
    $display("MUL 10*10 -> hi=%h lo=%h flags=%b", alu_hi, alu_out, obs[4:0]);
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      $display("FAIL mul_after_consume got=%b required=01", {out_valid, in_ready});
      failures++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (obs !== {1'b1, 8'h00, 8'h02, 5'b00000}) begin
      $display("FAIL held_beat got=%h required=%h", obs, {1'b1, 8'h00, 8'h02, 5'b00000});
      failures++;
    end
    $display("held ADD 01+01 -> out=%h", alu_out);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1; opcode = 4'h1; in_a = 8'h01; in_b = 8'h02;
    @(posedge clk); #1;
    in_a = 8'h10; in_b = 8'h20;
    checks++;
    if ({out_valid, alu_out, in_ready} !== {1'b1, 8'h03, 1'b0}) begin
      $display("FAIL b2b_first got=%h required=%h", {out_valid, alu_out, in_ready}, {1'b1, 8'h03, 1'b0});
      failures++;
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, alu_out, in_ready} !== {1'b1, 8'h03, 1'b0}) begin
      $display("FAIL b2b_stall got=%h required=%h", {out_valid, alu_out, in_ready}, {1'b1, 8'h03, 1'b0});
      failures++;
    end
    out_ready = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL b2b_ready_release got=%b required=1", in_ready);
      failures++;
    end
    @(posedge clk); #1;
    in_a = 8'h7F; in_b = 8'h01;
    checks++;
    if (obs !== {1'b1, 8'h00, 8'h30, 5'b00000}) begin
      $display("FAIL b2b_second got=%h required=%h", obs, {1'b1, 8'h00, 8'h30, 5'b00000});
      failures++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (obs !== {1'b1, 8'h00, 8'h80, 5'b00110}) begin
      $display("FAIL b2b_third got=%h required=%h", obs, {1'b1, 8'h00, 8'h80, 5'b00110});
      failures++;
    end
    $display("back-to-back: 03, 30, %h", alu_out);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL b2b_drain got=%b required=0", out_valid);
      failures++;
    end
  endtask

  task automatic test_ops();
    // {opcode, a, b, result, {zero,carry,neg,ovf,illegal}}
    logic [32:0] vec [19];
    logic [32:0] v;
    vec[0]  = {4'hF, 8'h00, 8'h00, 8'h00, 5'b00001};
    vec[1]  = {4'h9, 8'h81, 8'h01, 8'h02, 5'b01000};
    vec[2]  = {4'hD, 8'h01, 8'h01, 8'h80, 5'b00100};
    vec[3]  = {4'h8, 8'h81, 8'h01, 8'h40, 5'b01000};
    vec[4]  = {4'h9, 8'h81, 8'h00, 8'h81, 5'b00100};
    vec[5]  = {4'hE, 8'h80, 8'h01, 8'h01, 5'b00000};
    vec[6]  = {4'hB, 8'h80, 8'h00, 8'h80, 5'b01110};
    vec[7]  = {4'h3, 8'h7F, 8'h00, 8'h80, 5'b00110};
    vec[8]  = {4'h4, 8'h00, 8'h00, 8'hFF, 5'b01100};
    vec[9]  = {4'h7, 8'hF0, 8'hFF, 8'h0F, 5'b00000};
    vec[10] = {4'hA, 8'h0F, 8'h00, 8'hF0, 5'b00100};
    vec[11] = {4'h5, 8'hA0, 8'h05, 8'hA5, 5'b00100};
    vec[12] = {4'h6, 8'hA0, 8'h0F, 8'h00, 5'b10000};
    vec[13] = {4'h0, 8'h12, 8'h34, 8'h00, 5'b00001};
    vec[14] = {4'h1, 8'h7F, 8'h01, 8'h80, 5'b00110};
    vec[15] = {4'h9, 8'h01, 8'h07, 8'h80, 5'b00100};
    vec[16] = {4'h8, 8'h80, 8'h07, 8'h01, 5'b00000};
    vec[17] = {4'hD, 8'h03, 8'h02, 8'hC0, 5'b00100};
    vec[18] = {4'hB, 8'h00, 8'h00, 8'h00, 5'b10000};
    for (int i = 0; i < 19; i++) begin
      v = vec[i];
      issue(v[32:29], v[28:21], v[20:13]);
      checks++;
      if (obs !== {1'b1, 8'h00, v[12:0]}) begin
        $display("FAIL op_vec%0d op=%h got=%h required=%h", i, v[32:29], obs, {1'b1, 8'h00, v[12:0]});
        failures++;
      end
      $display("op=%h a=%h b=%h -> out=%h flags=%b", v[32:29], v[28:21], v[20:13], alu_out, obs[4:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul();
    logic stray;
    issue(4'hC, 8'h03, 8'h05);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0; #1;
    checks++;
    if ({obs, busy, in_ready} !== 24'h0) begin
      $display("FAIL midmul_reset got=%h required=%h", {obs, busy, in_ready}, 24'h0);
      failures++;
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL midmul_ready got=%b required=1", in_ready);
      failures++;
    end
    issue(4'h1, 8'h02, 8'h03);
    checks++;
    if (obs !== {1'b1, 8'h00, 8'h05, 5'b00000}) begin
      $display("FAIL midmul_add got=%h required=%h", obs, {1'b1, 8'h00, 8'h05, 5'b00000});
      failures++;
    end
    $display("after reset ADD 02+03 -> out=%h", alu_out);
    stray = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) stray = 1'b1;
    end
    checks++;
    if (stray !== 1'b0) begin
      $display("FAIL midmul_stray_result got=%b required=0", stray);
      failures++;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_add_sub();
    test_mul();
    test_back_to_back();
    test_ops();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
